pc_intr_seq: RTL
================

PC_INTR_SEQ -- requirements
Module: pc_intr_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning PC/return-address width.
REQ-002 SHALL have parameter NUM_IRQ, default 4, meaning interrupt channel count (1..8).
REQ-003 SHALL have parameter STACK_DEPTH, default 4, meaning nested-interrupt save-stack entries (1..8).
REQ-004 SHALL have parameter VEC_STRIDE, default 4, meaning address spacing between channel vectors.
REQ-005 SHALL have parameter RESET_PC, default 0, meaning PC value after reset.
REQ-006 SHALL have port clock  input  1  sole clock, rising edge.
REQ-007 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have port jmp_en  input  1  unconditional jump this cycle.
REQ-009 SHALL have port je_en  input  1  jump-if-flag this cycle.
REQ-010 SHALL have port ret  input  1  return-from-interrupt this cycle.
REQ-011 SHALL have port target  input  ADDR_W  jump destination.
REQ-012 SHALL have port flag_w_en  input  1  flag write strobe.
REQ-013 SHALL have port flag_in  input  1  flag write value.
REQ-014 SHALL have port int_en  input  1  global interrupt enable.
REQ-015 SHALL have port irq_req  input  NUM_IRQ  level-sensitive requests.
REQ-016 SHALL have port irq_mask  input  NUM_IRQ  per-channel enable, 1 = enabled.
REQ-017 SHALL have port vec_base  input  ADDR_W  vector table base.
REQ-018 SHALL have port pc  output  ADDR_W  current program counter.
REQ-019 SHALL have port flag  output  1  current flag.
REQ-020 SHALL have port irq_ack  output  NUM_IRQ  one-hot, one-cycle acknowledge pulse.
REQ-021 SHALL have port depth  output  clog2(STACK_DEPTH+1)  stack occupancy.
REQ-022 SHALL have port ret_err  output  1  sticky: ret with empty stack.

Function
REQ-023 SHALL compute seq_pc: target if jmp_en; target if je_en and flag=1; else pc+1, modulo 2^ADDR_W.
REQ-024 SHALL compute seq_flag: 0 if je_en; else flag_in if flag_w_en; else flag.
REQ-025 SHALL give jmp_en priority over je_en when both are asserted.
REQ-026 SHALL track cur_prio: NUM_IRQ when idle, else the index of the channel being serviced; index 0 has highest priority.
REQ-027 SHALL select the winner as the lowest index i with irq_req[i] & irq_mask[i].
REQ-028 SHALL take an interrupt only when int_en=1, a winner exists with index < cur_prio, depth < STACK_DEPTH, and ret=0.
REQ-029 On take, SHALL do all of the following at the clock edge: push {seq_pc, seq_flag, cur_prio}; set pc to vec_base + index*VEC_STRIDE (mod 2^ADDR_W); clear flag; set cur_prio to index; increment depth; pulse irq_ack[index] for exactly that cycle.
REQ-030 On ret with depth>0, SHALL pop the stack, restore pc, flag and cur_prio, and decrement depth; jmp_en, je_en and flag_w_en are ignored that cycle.
REQ-031 On ret with depth=0, SHALL set pc to pc+1, leave flag unchanged, and set ret_err until reset.
REQ-032 An interrupt blocked by a full stack, ret, masking or priority SHALL remain pending with no ack; it is re-evaluated every cycle.
REQ-033 SHALL, when no interrupt is taken and ret=0, load pc with seq_pc and flag with seq_flag.
REQ-034 SHALL drive outputs from registers only, with no combinational input-to-output path.

Reset
REQ-035 SHALL, on reset_n low, immediately set: pc = RESET_PC, flag = 0, irq_ack = 0, depth = 0, cur_prio = NUM_IRQ, ret_err = 0.
REQ-036 Stack contents SHALL need no reset; a reset mid-ISR discards all nesting.
REQ-037 SHALL hold the reset state while reset_n is low and start sequencing on the first rising edge after deassertion.

Verification
REQ-038 Sequential run: after reset, 5 idle cycles -> pc = 5; with ADDR_W=8 starting at pc = 0xFF -> next pc = 0x00.
REQ-039 Interrupt during jump: pc = 0x10, jmp_en, target = 0x40, irq_req[2], vec_base = 0x80 -> pc = 0x88, irq_ack = 0b0100, depth = 1; then ret -> pc = 0x40.
REQ-040 Nesting: servicing ch2, ch0 asserts -> preempts to vec_base+0 with depth = 2; ch3 asserts during ch0 ISR -> no ack; two rets restore in order.
REQ-041 Flag preservation: flag = 1, ch1 taken -> flag = 0 in ISR; ISR sets flag via flag_w_en=1, flag_in=0 (flag stays 0) -> ret restores flag = 1.
REQ-042 Full stack: STACK_DEPTH=1 and in ISR of ch3, ch0 asserts -> no ack until ret; the cycle after ret, ch0 is taken.
REQ-043 Errors and reset: ret at depth 0 -> ret_err = 1 and pc increments; reset_n low mid-ISR -> all REQ-035 values without waiting for a clock edge.

Source files
------------

// File: rtl/pc_intr_seq.sv
`default_nettype none
// ============================================================================
// Module   : pc_intr_seq
// Purpose  : Program counter sequencer with a jump / jump-if-flag unit and a
//            prioritised, nestable interrupt controller. Each interrupt entry
//            saves {next pc, next flag, current priority} on a small stack,
//            and a return restores them.
// Ports    : clock     - sole clock, rising edge
//            reset_n   - asynchronous active-low reset
//            jmp_en    - unconditional jump to target
//            je_en     - jump to target when flag=1 (clears flag)
//            ret       - return from interrupt
//            target    - jump destination
//            flag_w_en - flag write strobe, flag_in = value
//            int_en    - global interrupt enable
//            irq_req   - level-sensitive requests, irq_mask = per-channel enable
//            vec_base  - vector table base address
//            pc, flag  - current program counter and flag
//            irq_ack   - one-hot, one-cycle acknowledge pulse
//            depth     - save-stack occupancy
//            ret_err   - sticky: ret seen with an empty stack
// Revision : 1.0 - initial release
// ============================================================================
module pc_intr_seq #(
    parameter int ADDR_W      = 8,
    parameter int NUM_IRQ     = 4,
    parameter int STACK_DEPTH = 4,
    parameter int VEC_STRIDE  = 4,
    parameter int RESET_PC    = 0,
    localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               jmp_en,
    input  logic               je_en,
    input  logic               ret,
    input  logic [ADDR_W-1:0]  target,
    input  logic               flag_w_en,
    input  logic               flag_in,
    input  logic               int_en,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic [ADDR_W-1:0]  vec_base,
    output logic [ADDR_W-1:0]  pc,
    output logic               flag,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic [DEPTH_W-1:0] depth,
    output logic               ret_err
);

    // Priority needs one code beyond the last channel to mean "idle".
    localparam int PRIO_W = $clog2(NUM_IRQ + 1);

    logic [PRIO_W-1:0]  cur_prio;

    // Save stack; entry i holds the context pushed when depth was i.
    logic [ADDR_W-1:0]  stk_pc   [STACK_DEPTH];
    logic               stk_flag [STACK_DEPTH];
    logic [PRIO_W-1:0]  stk_prio [STACK_DEPTH];

    logic [ADDR_W-1:0]  seq_pc;
    logic               seq_flag;
    logic               win_valid;
    logic [PRIO_W-1:0]  win_idx;
    logic               take;
    logic [ADDR_W-1:0]  vec_addr;
    logic [NUM_IRQ-1:0] ack_next;
    logic [ADDR_W-1:0]  top_pc;
    logic               top_flag;
    logic [PRIO_W-1:0]  top_prio;

    // Normal sequencing; jmp_en dominates je_en because both select target.
    always_comb begin
        if (jmp_en || (je_en && flag)) begin
            seq_pc = target;
        end else begin
            seq_pc = pc + ADDR_W'(1);
        end
        if (je_en) begin
            seq_flag = 1'b0;
        end else if (flag_w_en) begin
            seq_flag = flag_in;
        end else begin
            seq_flag = flag;
        end
    end

    // Lowest enabled requesting index wins; scanning downward leaves the
    // lowest hit as the final assignment.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_req[i] && irq_mask[i]) begin
                win_valid = 1'b1;
                win_idx   = PRIO_W'(i);
            end
        end
    end

    assign take     = int_en && win_valid && (win_idx < cur_prio) &&
                      (depth < DEPTH_W'(STACK_DEPTH)) && !ret;
    assign vec_addr = vec_base + ADDR_W'(VEC_STRIDE * int'(win_idx));

    always_comb begin
        ack_next = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (take && (PRIO_W'(i) == win_idx)) begin
                ack_next[i] = 1'b1;
            end
        end
    end

    // Top-of-stack read mux (entry depth-1).
    always_comb begin
        top_pc   = '0;
        top_flag = 1'b0;
        top_prio = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (DEPTH_W'(i + 1) == depth) begin
                top_pc   = stk_pc[i];
                top_flag = stk_flag[i];
                top_prio = stk_prio[i];
            end
        end
    end

    // Stack storage carries no reset: depth alone defines what is valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (take && (DEPTH_W'(i) == depth)) begin
                stk_pc[i]   <= seq_pc;
                stk_flag[i] <= seq_flag;
                stk_prio[i] <= cur_prio;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= ADDR_W'(RESET_PC);
            flag     <= 1'b0;
            irq_ack  <= '0;
            depth    <= '0;
            cur_prio <= PRIO_W'(NUM_IRQ);
            ret_err  <= 1'b0;
        end else begin
            irq_ack <= ack_next;
            if (ret) begin
                if (depth != '0) begin
                    pc       <= top_pc;
                    flag     <= top_flag;
                    cur_prio <= top_prio;
                    depth    <= depth - DEPTH_W'(1);
                end else begin
                    pc      <= pc + ADDR_W'(1);
                    ret_err <= 1'b1;
                end
            end else if (take) begin
                pc       <= vec_addr;
                flag     <= 1'b0;
                cur_prio <= win_idx;
                depth    <= depth + DEPTH_W'(1);
            end else begin
                pc   <= seq_pc;
                flag <= seq_flag;
            end
        end
    end

endmodule
`default_nettype wire
